obi_copy_mgr: RTL and testbench



---
 rtl/obi_copy_mgr.sv | 224 ++++++++++++++++++++++
 tb/tb_obi_copy_mgr.sv | 432 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/obi_copy_mgr.sv
// obi_copy_mgr: OBI manager that copies a block of 32-bit words from a source
// address to a destination address, one outstanding transaction at a time.
// Each word is one OBI read followed by one OBI write.
//
// Optional build macro OBI_COPY_MGR_FILL_EN adds a fill mode. In fill mode the
// engine writes a pattern that is latched at start, and issues no reads.
module obi_copy_mgr #(
    parameter int unsigned MaxLenWidth = 16
) (
    input  logic                   clk_i,
    input  logic                   rst_i,

    // Configuration and control from the user registers
    input  logic                   start_i,
    input  logic [31:0]            src_addr_i,
    input  logic [31:0]            dst_addr_i,
    input  logic [MaxLenWidth-1:0] len_i,
`ifdef OBI_COPY_MGR_FILL_EN
    input  logic                   fill_i,
    input  logic [31:0]            pattern_i,
`endif

    // Status back to the user registers and the interrupt vector
    output logic                   busy_o,
    output logic                   done_irq_o,
    output logic                   err_o,
    output logic [MaxLenWidth-1:0] words_done_o,

    // OBI manager port
    output logic                   obi_req_o,
    input  logic                   obi_gnt_i,
    output logic [31:0]            obi_addr_o,
    output logic                   obi_we_o,
    output logic [3:0]             obi_be_o,
    output logic [31:0]            obi_wdata_o,
    input  logic                   obi_rvalid_i,
    input  logic [31:0]            obi_rdata_i,
    input  logic                   obi_err_i
);

    localparam logic [2:0] StIdle  = 3'd0;
    localparam logic [2:0] StRdReq = 3'd1;
    localparam logic [2:0] StRdRsp = 3'd2;
    localparam logic [2:0] StWrReq = 3'd3;
    localparam logic [2:0] StWrRsp = 3'd4;
    localparam logic [2:0] StFin   = 3'd5;

    localparam logic [MaxLenWidth-1:0] LenZero = '0;
    localparam logic [MaxLenWidth-1:0] LenOne  = MaxLenWidth'(1);

    logic [2:0]             state_q, state_d;
    logic [31:0]            src_q, src_d;
    logic [31:0]            dst_q, dst_d;
    logic [MaxLenWidth-1:0] rem_q, rem_d;
    logic [31:0]            data_q, data_d;
    logic                   err_q, err_d;
    logic [MaxLenWidth-1:0] cnt_q, cnt_d;

    // Fill-mode selection; constant zero when the feature is not built.
    logic                   start_fill;
    logic                   fill_mode;
    logic [31:0]            start_pattern;

`ifdef OBI_COPY_MGR_FILL_EN
    logic                   fill_q, fill_d;

    assign start_fill    = fill_i;
    assign start_pattern = pattern_i;
    assign fill_mode     = fill_q;

    // Latch the fill selection for the duration of a job.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            fill_q <= 1'b0;
        end else begin
            fill_q <= fill_d;
        end
    end

    // Fill selection only changes when a start is accepted.
    always_comb begin
        fill_d = fill_q;
        if (state_q == StIdle && start_i) begin
            fill_d = fill_i;
        end
    end
`else
    assign start_fill    = 1'b0;
    assign start_pattern = 32'h0;
    assign fill_mode     = 1'b0;
`endif

    // State and datapath registers; reset aborts any job and drops the request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            src_q   <= 32'h0;
            dst_q   <= 32'h0;
            rem_q   <= '0;
            data_q  <= 32'h0;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            rem_q   <= rem_d;
            data_q  <= data_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic: sequencing of read/write pairs per word.
    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        rem_d   = rem_q;
        data_d  = data_q;
        err_d   = err_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    // Low address bits are dropped; all accesses are word-sized.
                    src_d = src_addr_i & 32'hFFFF_FFFC;
                    dst_d = dst_addr_i & 32'hFFFF_FFFC;
                    rem_d = len_i;
                    err_d = 1'b0;
                    cnt_d = '0;
                    if (start_fill) begin
                        data_d = start_pattern;
                    end
                    if (len_i == LenZero) begin
                        state_d = StFin;
                    end else if (start_fill) begin
                        state_d = StWrReq;
                    end else begin
                        state_d = StRdReq;
                    end
                end
            end

            StRdReq: begin
                if (obi_gnt_i) begin
                    state_d = StRdRsp;
                end
            end

            StRdRsp: begin
                if (obi_rvalid_i) begin
                    if (obi_err_i) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        data_d  = obi_rdata_i;
                        state_d = StWrReq;
                    end
                end
            end

            StWrReq: begin
                if (obi_gnt_i) begin
                    state_d = StWrRsp;
                end
            end

            StWrRsp: begin
                if (obi_rvalid_i) begin
                    if (obi_err_i) begin
                        err_d   = 1'b1;
                        state_d = StFin;
                    end else begin
                        cnt_d = cnt_q + LenOne;
                        // 32-bit wrap from 0xFFFF_FFFC to 0 is intentional.
                        src_d = src_q + 32'd4;
                        dst_d = dst_q + 32'd4;
                        rem_d = rem_q - LenOne;
                        if (rem_q == LenOne) begin
                            state_d = StFin;
                        end else if (fill_mode) begin
                            state_d = StWrReq;
                        end else begin
                            state_d = StRdReq;
                        end
                    end
                end
            end

            StFin: begin
                // Starts coinciding with completion are dropped.
                state_d = StIdle;
            end

            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Outputs decoded from registered state, so they are glitch-free and
    // return to reset values as soon as reset asserts.
    always_comb begin
        busy_o       = (state_q != StIdle);
        done_irq_o   = (state_q == StFin);
        err_o        = err_q;
        words_done_o = cnt_q;

        obi_req_o    = (state_q == StRdReq) || (state_q == StWrReq);
        obi_we_o     = (state_q == StWrReq);
        obi_be_o     = 4'hF;
        obi_addr_o   = 32'h0;
        obi_wdata_o  = 32'h0;
        if (state_q == StRdReq) begin
            obi_addr_o = src_q;
        end else if (state_q == StWrReq) begin
            obi_addr_o  = dst_q;
            obi_wdata_o = data_q;
        end
    end

endmodule

// File: tb/tb_obi_copy_mgr.sv
// Directed self-checking bench for obi_copy_mgr with a behavioural OBI memory.
// Define OBI_COPY_MGR_FILL_EN to also build and exercise fill mode.
module tb_obi_copy_mgr;

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] src_addr;
    logic [31:0] dst_addr;
    logic [15:0] len;
`ifdef OBI_COPY_MGR_FILL_EN
    logic        fill;
    logic [31:0] pattern;
`endif
    logic        busy;
    logic        done_irq;
    logic        err;
    logic [15:0] words_done;
    logic        obi_req;
    logic        obi_gnt;
    logic [31:0] obi_addr;
    logic        obi_we;
    logic [3:0]  obi_be;
    logic [31:0] obi_wdata;
    logic        obi_rvalid;
    logic [31:0] obi_rdata;
    logic        obi_err;

    int checks;
    int failures;

    // Memory model state
    logic [31:0] mem [logic [31:0]];
    int          stall_cycles;
    int          stall_cnt;
    int          rd_cnt;
    int          wr_cnt;
    int          err_at_rd;
    logic        rsp_valid;
    logic        rsp_err;
    logic [31:0] rsp_rdata;
    logic        inj_valid;
    logic        inj_err;

    // Stability monitor state
    logic        mon_en;
    logic        prev_pend;
    logic [31:0] p_addr;
    logic        p_we;
    logic [31:0] p_wdata;
    int          stab_viol;
    int          stall_seen;

    obi_copy_mgr #(
        .MaxLenWidth(16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .start_i      (start),
        .src_addr_i   (src_addr),
        .dst_addr_i   (dst_addr),
        .len_i        (len),
`ifdef OBI_COPY_MGR_FILL_EN
        .fill_i       (fill),
        .pattern_i    (pattern),
`endif
        .busy_o       (busy),
        .done_irq_o   (done_irq),
        .err_o        (err),
        .words_done_o (words_done),
        .obi_req_o    (obi_req),
        .obi_gnt_i    (obi_gnt),
        .obi_addr_o   (obi_addr),
        .obi_we_o     (obi_we),
        .obi_be_o     (obi_be),
        .obi_wdata_o  (obi_wdata),
        .obi_rvalid_i (obi_rvalid),
        .obi_rdata_i  (obi_rdata),
        .obi_err_i    (obi_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign obi_gnt    = obi_req && (stall_cnt >= stall_cycles);
    assign obi_rvalid = rsp_valid | inj_valid;
    assign obi_err    = rsp_err | inj_err;
    assign obi_rdata  = rsp_rdata;

    // Memory: grant after stall_cycles, respond one cycle after the grant.
    always @(posedge clk) begin
        if (rst) begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            stall_cnt <= 0;
        end else begin
            rsp_valid <= 1'b0;
            rsp_err   <= 1'b0;
            if (obi_req && obi_gnt) begin
                stall_cnt <= 0;
                rsp_valid <= 1'b1;
                if (obi_we) begin
                    mem[obi_addr] = obi_wdata;
                    wr_cnt <= wr_cnt + 1;
                end else begin
                    rsp_rdata <= mem.exists(obi_addr) ? mem[obi_addr] : 32'hDEAD_BEEF;
                    if (rd_cnt + 1 == err_at_rd) rsp_err <= 1'b1;
                    rd_cnt <= rd_cnt + 1;
                end
            end else if (obi_req) begin
                stall_cnt <= stall_cnt + 1;
            end else begin
                stall_cnt <= 0;
            end
        end
    end

    // Watch for request fields changing, or request dropping, before grant.
    always @(negedge clk) begin
        if (mon_en && prev_pend) begin
            if (!obi_req) stab_viol = stab_viol + 1;
            else if (obi_addr !== p_addr || obi_we !== p_we || obi_wdata !== p_wdata)
                stab_viol = stab_viol + 1;
            else stall_seen = stall_seen + 1;
        end
        prev_pend = obi_req && !obi_gnt;
        p_addr    = obi_addr;
        p_we      = obi_we;
        p_wdata   = obi_wdata;
    end

    task automatic do_start(input logic [31:0] s, input logic [31:0] d, input logic [15:0] l);
        @(negedge clk);
        src_addr = s;
        dst_addr = d;
        len      = l;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
    endtask

    // Counts negedges until busy drops (bounded) and done pulses seen.
    task automatic run_to_idle(output int n, output int pulses);
        n = 0;
        pulses = 0;
        while (n < 2000) begin
            if (done_irq) pulses = pulses + 1;
            if (!busy) break;
            @(negedge clk);
            n = n + 1;
        end
    endtask

    task automatic test_reset();
        #2;
        checks = checks + 1;
        if (busy !== 1'b0 || done_irq !== 1'b0 || err !== 1'b0 || words_done !== 16'd0) begin
            failures = failures + 1;
            $display("FAIL reset_status: busy=%b done=%b err=%b words=%0d want 0 0 0 0",
                     busy, done_irq, err, words_done);
        end
        checks = checks + 1;
        if (obi_req !== 1'b0 || obi_addr !== 32'h0 || obi_we !== 1'b0 ||
            obi_wdata !== 32'h0 || obi_be !== 4'hF) begin
            failures = failures + 1;
            $display("FAIL reset_obi: req=%b addr=%h we=%b wdata=%h be=%h want 0 0 0 0 f",
                     obi_req, obi_addr, obi_we, obi_wdata, obi_be);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_copy();
        int n, p, rd0, wr0;
        logic [31:0] exp [3];
        exp[0] = 32'h1111_1111;
        exp[1] = 32'h2222_2222;
        exp[2] = 32'h3333_3333;
        stall_cycles = 0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        do_start(32'h1000_0000, 32'h1000_0100, 16'd3);
        run_to_idle(n, p);
        checks = checks + 1;
        if (n !== 13) begin
            failures = failures + 1;
            $display("FAIL copy_cycles: got %0d want 13", n);
        end
        checks = checks + 1;
        if (p !== 1) begin
            failures = failures + 1;
            $display("FAIL copy_done_pulses: got %0d want 1", p);
        end
        checks = checks + 1;
        if (words_done !== 16'd3 || err !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL copy_status: words=%0d err=%b want 3 0", words_done, err);
        end
        checks = checks + 1;
        if (rd_cnt - rd0 !== 3 || wr_cnt - wr0 !== 3) begin
            failures = failures + 1;
            $display("FAIL copy_xfers: rd=%0d wr=%0d want 3 3", rd_cnt - rd0, wr_cnt - wr0);
        end
        for (int i = 0; i < 3; i++) begin
            checks = checks + 1;
            if (mem[32'h1000_0100 + 4 * i] !== exp[i]) begin
                failures = failures + 1;
                $display("FAIL copy_word%0d: got %h want %h", i,
                         mem[32'h1000_0100 + 4 * i], exp[i]);
            end
        end
    endtask

    task automatic test_grant_stall();
        int n, p, sv0, ss0;
        logic [31:0] exp [3];
        exp[0] = 32'h1111_1111;
        exp[1] = 32'h2222_2222;
        exp[2] = 32'h3333_3333;
        stall_cycles = 5;
        sv0 = stab_viol;
        ss0 = stall_seen;
        // Unaligned addresses exercise the dropped low bits.
        do_start(32'h1000_0002, 32'h1000_0301, 16'd3);
        // A start while busy must not disturb the running job.
        src_addr = 32'h2000_0000;
        dst_addr = 32'h2000_0000;
        len      = 16'd1;
        start    = 1'b1;
        @(negedge clk);
        start    = 1'b0;
        run_to_idle(n, p);
        stall_cycles = 0;
        checks = checks + 1;
        if (stab_viol - sv0 !== 0 || stall_seen - ss0 < 20) begin
            failures = failures + 1;
            $display("FAIL stall_stable: violations=%0d stalled_cycles=%0d want 0 >=20",
                     stab_viol - sv0, stall_seen - ss0);
        end
        checks = checks + 1;
        if (words_done !== 16'd3 || p !== 1 || n >= 2000) begin
            failures = failures + 1;
            $display("FAIL stall_status: words=%0d pulses=%0d want 3 1", words_done, p);
        end
        for (int i = 0; i < 3; i++) begin
            checks = checks + 1;
            if (mem[32'h1000_0300 + 4 * i] !== exp[i]) begin
                failures = failures + 1;
                $display("FAIL stall_word%0d: got %h want %h", i,
                         mem[32'h1000_0300 + 4 * i], exp[i]);
            end
        end
    endtask

    task automatic test_error();
        int n, p, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        err_at_rd = rd_cnt + 2;
        do_start(32'h1000_0000, 32'h1000_0600, 16'd4);
        run_to_idle(n, p);
        checks = checks + 1;
        if (err !== 1'b1 || words_done !== 16'd1 || p !== 1) begin
            failures = failures + 1;
            $display("FAIL err_status: err=%b words=%0d pulses=%0d want 1 1 1",
                     err, words_done, p);
        end
        repeat (5) @(negedge clk);
        checks = checks + 1;
        if (rd_cnt - rd0 !== 2 || wr_cnt - wr0 !== 1 || obi_req !== 1'b0) begin
            failures = failures + 1;
            $display("FAIL err_no_more_req: rd=%0d wr=%0d req=%b want 2 1 0",
                     rd_cnt - rd0, wr_cnt - wr0, obi_req);
        end
        err_at_rd = 0;
        do_start(32'h1000_0000, 32'h1000_0600, 16'd0);
        checks = checks + 1;
        if (err !== 1'b0 || words_done !== 16'd0) begin
            failures = failures + 1;
            $display("FAIL err_cleared: err=%b words=%0d want 0 0", err, words_done);
        end
        run_to_idle(n, p);
    endtask

    task automatic test_len_zero();
        int n, p, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        do_start(32'h1000_0000, 32'h1000_0700, 16'd0);
        checks = checks + 1;
        if (done_irq !== 1'b1 || busy !== 1'b1) begin
            failures = failures + 1;
            $display("FAIL len0_fin: done=%b busy=%b want 1 1", done_irq, busy);
        end
        run_to_idle(n, p);
        checks = checks + 1;
        if (n !== 1 || p !== 1 || rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 0) begin
            failures = failures + 1;
            $display("FAIL len0_run: busy_cycles=%0d pulses=%0d rd=%0d wr=%0d want 1 1 0 0",
                     n, p, rd_cnt - rd0, wr_cnt - wr0);
        end
    endtask

    task automatic test_reset_mid();
        int n, p, wr0, k;
        stall_cycles = 3;
        do_start(32'h1000_0000, 32'h1000_0400, 16'd2);
        k = 0;
        while (!(obi_req && obi_we) && k < 100) begin
            @(negedge clk);
            k = k + 1;
        end
        checks = checks + 1;
        if (k >= 100) begin
            failures = failures + 1;
            $display("FAIL rstmid_reach_wr: timeout got busy=%b want write request", busy);
        end
        mon_en = 1'b0;
        rst = 1'b1;
        #1;
        checks = checks + 1;
        if (busy !== 1'b0 || done_irq !== 1'b0 || err !== 1'b0 || words_done !== 16'd0 ||
            obi_req !== 1'b0 || obi_addr !== 32'h0 || obi_we !== 1'b0 ||
            obi_wdata !== 32'h0 || obi_be !== 4'hF) begin
            failures = failures + 1;
            $display("FAIL rstmid_outputs: busy=%b req=%b addr=%h we=%b wdata=%h want 0 0 0 0 0",
                     busy, obi_req, obi_addr, obi_we, obi_wdata);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        stall_cycles = 0;
        wr0 = wr_cnt;
        inj_valid = 1'b1;
        inj_err   = 1'b1;
        @(negedge clk);
        inj_valid = 1'b0;
        inj_err   = 1'b0;
        @(negedge clk);
        checks = checks + 1;
        if (busy !== 1'b0 || err !== 1'b0 || obi_req !== 1'b0 || wr_cnt - wr0 !== 0) begin
            failures = failures + 1;
            $display("FAIL rstmid_late_rvalid: busy=%b err=%b req=%b wr=%0d want 0 0 0 0",
                     busy, err, obi_req, wr_cnt - wr0);
        end
        mon_en = 1'b1;
        do_start(32'h1000_0004, 32'h1000_0500, 16'd2);
        run_to_idle(n, p);
        checks = checks + 1;
        if (n !== 9 || words_done !== 16'd2 || mem[32'h1000_0500] !== 32'h2222_2222 ||
            mem[32'h1000_0504] !== 32'h3333_3333) begin
            failures = failures + 1;
            $display("FAIL rstmid_fresh_copy: cycles=%0d words=%0d w0=%h w1=%h want 9 2 22222222 33333333",
                     n, words_done, mem[32'h1000_0500], mem[32'h1000_0504]);
        end
    endtask

`ifdef OBI_COPY_MGR_FILL_EN
    task automatic test_fill();
        int n, p, rd0, wr0;
        rd0 = rd_cnt;
        wr0 = wr_cnt;
        fill    = 1'b1;
        pattern = 32'hA5A5_A5A5;
        do_start(32'h1000_0000, 32'h1000_0200, 16'd2);
        fill    = 1'b0;
        pattern = 32'h0;
        run_to_idle(n, p);
        checks = checks + 1;
        if (rd_cnt - rd0 !== 0 || wr_cnt - wr0 !== 2 || n !== 5 || p !== 1) begin
            failures = failures + 1;
            $display("FAIL fill_run: rd=%0d wr=%0d cycles=%0d pulses=%0d want 0 2 5 1",
                     rd_cnt - rd0, wr_cnt - wr0, n, p);
        end
        checks = checks + 1;
        if (mem[32'h1000_0200] !== 32'hA5A5_A5A5 || mem[32'h1000_0204] !== 32'hA5A5_A5A5) begin
            failures = failures + 1;
            $display("FAIL fill_words: w0=%h w1=%h want a5a5a5a5 a5a5a5a5",
                     mem[32'h1000_0200], mem[32'h1000_0204]);
        end
    endtask
`endif

    initial begin
        checks       = 0;
        failures     = 0;
        rst          = 1'b1;
        start        = 1'b0;
        src_addr     = 32'h0;
        dst_addr     = 32'h0;
        len          = 16'd0;
`ifdef OBI_COPY_MGR_FILL_EN
        fill         = 1'b0;
        pattern      = 32'h0;
`endif
        stall_cycles = 0;
        rd_cnt       = 0;
        wr_cnt       = 0;
        err_at_rd    = 0;
        rsp_rdata    = 32'h0;
        inj_valid    = 1'b0;
        inj_err      = 1'b0;
        mon_en       = 1'b1;
        stab_viol    = 0;
        stall_seen   = 0;
        mem[32'h1000_0000] = 32'h1111_1111;
        mem[32'h1000_0004] = 32'h2222_2222;
        mem[32'h1000_0008] = 32'h3333_3333;
        mem[32'h1000_000C] = 32'h4444_4444;
        for (int i = 0; i < 4; i++) begin
            mem[32'h1000_0100 + 4 * i] = 32'h0;
            mem[32'h1000_0200 + 4 * i] = 32'h0;
            mem[32'h1000_0300 + 4 * i] = 32'h0;
            mem[32'h1000_0500 + 4 * i] = 32'h0;
        end

        test_reset();
        test_copy();
        test_grant_stall();
        test_error();
        test_len_zero();
        test_reset_mid();
`ifdef OBI_COPY_MGR_FILL_EN
        test_fill();
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
